// File: rtl/fetch_if.sv
// Instruction memory channel between fetch and imem.
// Single-outstanding read request with in-order response.
interface fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch.sv
// Beta instruction fetch stage: PC, imem requests,
// one-entry skid buffer and redirect/squash handling.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008,
  parameter logic [31:0] NOP_INST = 32'h83FF_F800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] branch_addr,
  input  logic [31:0] jump_addr,
  fetch_if.master     imem,
  output logic [31:0] inst,
  output logic [31:0] pc_plus_four,
  output logic        inst_valid
);

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic        r_squash;
  logic        w_squash_nxt;
  logic [31:0] r_skid_data;
  logic [31:0] r_skid_pc4;
  logic        r_skid_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc4;
  logic        r_valid;

  logic        w_redirect;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rsp;
  logic        w_hs;
  logic        w_busy_nxt;

  // Redirect decode and target selection
  always_comb begin
    w_redirect   = (pc_sel >= 3'd1) && (pc_sel <= 3'd4);
    w_target_raw = r_pc;
    case (pc_sel)
      3'd1:    w_target_raw = branch_addr;
      3'd2:    w_target_raw = {jump_addr[31] & r_pc[31],
                               jump_addr[30:0]};
      3'd3:    w_target_raw = ILLOP_PC;
      3'd4:    w_target_raw = XADR_PC;
      default: w_target_raw = r_pc;
    endcase
    w_target = {w_target_raw[31:2], 2'b00};
    w_pc_inc = {r_pc[31], r_pc[30:0] + 31'd4};
  end

  // Request issue, response acceptance and next state
  always_comb begin
    w_req        = 1'b0;
    w_addr       = r_pc;
    w_rsp        = 1'b0;
    w_state_nxt  = r_state;
    w_squash_nxt = r_squash;
    case (r_state)
      S_REQ: begin
        w_req  = !r_skid_valid;
        w_addr = r_pc;
      end
      S_WAIT: begin
        if (imem.imem_rvalid && !r_squash) begin
          w_rsp = 1'b1;
          if (!stall && !r_skid_valid) begin
            w_req  = 1'b1;
            w_addr = w_pc_inc;
          end
        end
      end
      default: begin
        w_req = 1'b0;
      end
    endcase
    w_req = w_req & !rst;
    w_hs  = w_req & imem.imem_ready;
    // A request is in flight next cycle if one is
    // still pending or one is accepted now.
    w_busy_nxt = ((r_state == S_WAIT) && !imem.imem_rvalid)
               || w_hs;
    w_state_nxt = w_busy_nxt ? S_WAIT : S_REQ;
    if (w_redirect)
      w_squash_nxt = w_busy_nxt;
    else if ((r_state == S_WAIT) && imem.imem_rvalid)
      w_squash_nxt = 1'b0;
  end

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = w_addr;

  // FSM state, squash flag and program counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_squash <= 1'b0;
      r_pc     <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_squash <= w_squash_nxt;
      if (w_redirect)
        r_pc <= w_target;
      else if (w_rsp)
        r_pc <= w_pc_inc;
    end
  end

  // Output register and skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst       <= NOP_INST;
      r_pc4        <= 32'h0;
      r_valid      <= 1'b0;
      r_skid_data  <= 32'h0;
      r_skid_pc4   <= 32'h0;
      r_skid_valid <= 1'b0;
    end else if (w_redirect) begin
      r_inst       <= NOP_INST;
      r_valid      <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (!stall) begin
        if (r_skid_valid) begin
          r_inst       <= r_skid_data;
          r_pc4        <= r_skid_pc4;
          r_valid      <= 1'b1;
          r_skid_valid <= 1'b0;
        end else if (w_rsp) begin
          r_inst  <= imem.imem_rdata;
          r_pc4   <= w_pc_inc;
          r_valid <= 1'b1;
        end else begin
          r_inst  <= NOP_INST;
          r_valid <= 1'b0;
        end
      end
      if (w_rsp && (stall || r_skid_valid)) begin
        r_skid_data  <= imem.imem_rdata;
        r_skid_pc4   <= w_pc_inc;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign inst         = r_inst;
  assign pc_plus_four = r_pc4;
  assign inst_valid   = r_valid;

endmodule

// File: tb/tb_fetch.sv
// Testbench for fetch: imem model with variable latency,
// directed scenarios and a randomized program-order scoreboard.
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] ILLOP  = 32'h8000_0004;
  localparam logic [31:0] XADR   = 32'h8000_0008;
  localparam logic [31:0] NOP    = 32'h83FF_F800;
  localparam logic [31:0] XK     = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  pc_sel = 3'd0;
  logic [31:0] branch_addr = 32'h0;
  logic [31:0] jump_addr = 32'h0;
  logic [31:0] inst;
  logic [31:0] pc_plus_four;
  logic        inst_valid;

  fetch_if imem();

  fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .pc_sel       (pc_sel),
    .branch_addr  (branch_addr),
    .jump_addr    (jump_addr),
    .imem         (imem),
    .inst         (inst),
    .pc_plus_four (pc_plus_four),
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    int          rem;
  } mreq_t;

  mreq_t       mq[$];
  int          vectors = 0;
  int          errors = 0;
  int          mem_k = 1;
  int          rdy_pct = 100;
  int          overlap = 0;
  int          misalign = 0;
  logic        last_req;
  logic        last_hs;
  logic [31:0] last_addr;

  function automatic logic [31:0] f_inc(input logic [31:0] p);
    return (p & 32'h8000_0000) | ((p + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] f_target(
    input logic [2:0] sel, input logic [31:0] b,
    input logic [31:0] j, input logic sup);
    logic [31:0] t;
    case (sel)
      3'd1: t = b;
      3'd2: t = sup ? j : (j & 32'h7FFF_FFFF);
      3'd3: t = ILLOP;
      default: t = XADR;
    endcase
    return t & 32'hFFFF_FFFC;
  endfunction

  // One clock cycle: drive memory, sample request, advance.
  task automatic cyc();
    logic rv;
    int   k;
    rv = (mq.size() > 0) && (mq[0].rem == 0);
    imem.imem_rvalid = rv;
    imem.imem_rdata  = rv ? (mq[0].a ^ XK) : $urandom;
    imem.imem_ready  = ($urandom_range(0, 99) < rdy_pct);
    #1;
    last_req  = imem.imem_req;
    last_addr = imem.imem_addr;
    last_hs   = imem.imem_req & imem.imem_ready;
    if (last_hs && (mq.size() - (rv ? 1 : 0)) != 0) overlap++;
    if (last_hs && last_addr[1:0] != 2'b00) misalign++;
    @(posedge clk);
    if (rst) begin
      mq.delete();
    end else begin
      if (rv) void'(mq.pop_front());
      else if (mq.size() > 0) mq[0].rem = mq[0].rem - 1;
      if (last_hs) begin
        k = (mem_k == 0) ? $urandom_range(1, 3) : mem_k;
        mq.push_back('{last_addr, k - 1});
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_req(output logic [31:0] a, output bit ok);
    ok = 1'b0;
    a  = 32'h0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (last_req) begin
        a  = last_addr;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_redirect(
    input logic [2:0] sel, input logic [31:0] b,
    input logic [31:0] j, output logic v,
    output logic [31:0] a, output bit ok);
    pc_sel = sel;
    branch_addr = b;
    jump_addr = j;
    cyc();
    pc_sel = 3'd0;
    v = inst_valid;
    wait_req(a, ok);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    vectors++;
    if (last_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req0: got %b want 0", last_req);
    end
    cyc();
    vectors++;
    if (inst !== NOP || inst_valid !== 1'b0 ||
        pc_plus_four !== 32'h0 || last_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_state: inst %h v %b pc4 %h req %b",
               inst, inst_valid, pc_plus_four, last_req);
    end
    rst = 1'b0;
    cyc();
    vectors++;
    if (last_req !== 1'b1 || last_addr !== RST_PC) begin
      errors++;
      $display("FAIL rst_first_req: req %b addr %h want 1 %h",
               last_req, last_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    logic [31:0] a;
    cyc();
    a = RST_PC;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (inst_valid !== 1'b1 || inst !== (a ^ XK) ||
          pc_plus_four !== f_inc(a)) begin
        errors++;
        $display("FAIL stream[%0d]: v %b inst %h pc4 %h want %h %h",
                 i, inst_valid, inst, pc_plus_four, a ^ XK, f_inc(a));
      end
      a = f_inc(a);
      cyc();
    end
  endtask

  task automatic test_stall();
    logic [31:0] h_inst;
    logic [31:0] h_pc4;
    logic [31:0] e;
    int          got;
    h_inst = inst;
    h_pc4  = pc_plus_four;
    vectors++;
    if (inst_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_pre_valid: got %b want 1", inst_valid);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (last_req !== 1'b0 || inst !== h_inst ||
          pc_plus_four !== h_pc4) begin
        errors++;
        $display("FAIL stall_hold[%0d]: req %b inst %h pc4 %h want 0 %h %h",
                 i, last_req, inst, pc_plus_four, h_inst, h_pc4);
      end
    end
    stall = 1'b0;
    e   = h_pc4;
    got = 0;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid && got < 3) begin
        vectors++;
        if (pc_plus_four !== e) begin
          errors++;
          $display("FAIL stall_order[%0d]: pc4 %h want %h",
                   got, pc_plus_four, e);
        end
        e = f_inc(e);
        got++;
      end
      if (got == 3) break;
      cyc();
    end
    vectors++;
    if (got != 3) begin
      errors++;
      $display("FAIL stall_drain: got %0d insts want 3", got);
    end
  endtask

  task automatic test_branch_squash();
    logic [31:0] a;
    bit          ok;
    bit          seen;
    mem_k = 3;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (last_hs) break;
    end
    pc_sel = 3'd1;
    branch_addr = 32'h0000_0103;
    cyc();
    pc_sel = 3'd0;
    vectors++;
    if (inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_bubble: v %b want 0", inst_valid);
    end
    wait_req(a, ok);
    vectors++;
    if (!ok || a !== 32'h0000_0100) begin
      errors++;
      $display("FAIL br_addr: ok %0d addr %h want 00000100", ok, a);
    end
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (inst_valid) begin
        seen = 1'b1;
        break;
      end
      cyc();
    end
    vectors++;
    if (!seen || pc_plus_four !== 32'h0000_0104 ||
        inst !== (32'h0000_0100 ^ XK)) begin
      errors++;
      $display("FAIL br_first: seen %0d pc4 %h inst %h want 00000104 %h",
               seen, pc_plus_four, inst, 32'h0000_0100 ^ XK);
    end
    mem_k = 1;
  endtask

  task automatic test_jump_priv();
    logic [31:0] a;
    logic        v;
    bit          ok;
    do_redirect(3'd1, 32'h0000_0200, 32'h0, v, a, ok);
    do_redirect(3'd2, 32'h0, 32'h8000_0010, v, a, ok);
    vectors++;
    if (!ok || a !== 32'h0000_0010 || v !== 1'b0) begin
      errors++;
      $display("FAIL jmp_user: ok %0d addr %h v %b want 00000010",
               ok, a, v);
    end
    do_redirect(3'd1, 32'h8000_0200, 32'h0, v, a, ok);
    do_redirect(3'd2, 32'h0, 32'h8000_0010, v, a, ok);
    vectors++;
    if (!ok || a !== 32'h8000_0010) begin
      errors++;
      $display("FAIL jmp_sup: ok %0d addr %h want 80000010", ok, a);
    end
    do_redirect(3'd3, 32'h0, 32'h0, v, a, ok);
    vectors++;
    if (!ok || a !== ILLOP) begin
      errors++;
      $display("FAIL illop: ok %0d addr %h want %h", ok, a, ILLOP);
    end
    do_redirect(3'd4, 32'h0, 32'h0, v, a, ok);
    vectors++;
    if (!ok || a !== XADR) begin
      errors++;
      $display("FAIL xadr: ok %0d addr %h want %h", ok, a, XADR);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a;
    logic        v;
    bit          ok;
    do_redirect(3'd1, 32'h7FFF_FFFC, 32'h0, v, a, ok);
    wait_req(a, ok);
    vectors++;
    if (!ok || a !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_user: ok %0d addr %h want 00000000", ok, a);
    end
    do_redirect(3'd1, 32'hFFFF_FFFC, 32'h0, v, a, ok);
    wait_req(a, ok);
    vectors++;
    if (!ok || a !== 32'h8000_0000) begin
      errors++;
      $display("FAIL wrap_sup: ok %0d addr %h want 80000000", ok, a);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] p_inst;
    logic [31:0] p_pc4;
    logic        p_v;
    logic        p_stall;
    logic        p_redir;
    logic        redir;
    int          consumed;
    mem_k   = 0;
    rdy_pct = 75;
    stall   = 1'b1;
    pc_sel  = 3'd1;
    branch_addr = $urandom;
    exp_pc  = branch_addr & 32'hFFFF_FFFC;
    cyc();
    p_redir  = 1'b1;
    p_stall  = 1'b1;
    p_inst   = 32'h0;
    p_pc4    = 32'h0;
    p_v      = 1'b0;
    consumed = 0;
    for (int n = 1; n < 3000; n++) begin
      if (p_redir) begin
        vectors++;
        if (inst_valid !== 1'b0) begin
          errors++;
          $display("FAIL rnd_bubble@%0d: v %b want 0", n, inst_valid);
        end
      end else if (p_stall) begin
        vectors++;
        if (inst !== p_inst || pc_plus_four !== p_pc4 ||
            inst_valid !== p_v) begin
          errors++;
          $display("FAIL rnd_hold@%0d: %h %h %b want %h %h %b", n,
                   inst, pc_plus_four, inst_valid, p_inst, p_pc4, p_v);
        end
      end
      if (inst_valid === 1'b0) begin
        vectors++;
        if (inst !== NOP) begin
          errors++;
          $display("FAIL rnd_nop@%0d: inst %h want %h", n, inst, NOP);
        end
      end
      stall  = ($urandom_range(0, 99) < 30);
      pc_sel = ($urandom_range(0, 99) < 5) ?
               3'($urandom_range(1, 7)) : 3'd0;
      branch_addr = $urandom;
      jump_addr   = $urandom;
      if (!stall && inst_valid) begin
        vectors++;
        if (inst !== (exp_pc ^ XK) ||
            pc_plus_four !== f_inc(exp_pc)) begin
          errors++;
          $display("FAIL rnd_seq@%0d: inst %h pc4 %h want %h %h", n,
                   inst, pc_plus_four, exp_pc ^ XK, f_inc(exp_pc));
        end
        exp_pc = f_inc(exp_pc);
        consumed++;
      end
      redir = (pc_sel >= 3'd1) && (pc_sel <= 3'd4);
      if (redir)
        exp_pc = f_target(pc_sel, branch_addr, jump_addr, exp_pc[31]);
      p_inst  = inst;
      p_pc4   = pc_plus_four;
      p_v     = inst_valid;
      p_stall = stall;
      p_redir = redir;
      cyc();
    end
    stall  = 1'b0;
    pc_sel = 3'd0;
    vectors++;
    if (overlap != 0 || misalign != 0) begin
      errors++;
      $display("FAIL mem_protocol: overlap %0d misalign %0d want 0 0",
               overlap, misalign);
    end
    vectors++;
    if (consumed < 100) begin
      errors++;
      $display("FAIL rnd_progress: consumed %0d want >= 100", consumed);
    end
  endtask

  initial begin
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_branch_squash();
    test_jump_priv();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
